cpu_hs_param: RTL and testbench
===============================

// Module: cpu_hs_param
// PURPOSE
//  Parametrised successor of the 8-bit accumulator CPU (A/B regs, NZVC CCR, fetch/decode/execute FSM).
//  Generalises data/address width and replaces fixed-latency memory access with a req/ready handshake,
//  so wait-stated RAM or a bus arbiter can sit between core and memory. Adds a HALT state and status outputs.
// PARAMETERS
//  DATA_W    8   register/data width; must be >= 8. Opcode is IR[7:0], upper IR bits are ignored.
//  ADDR_W    8   PC/MAR width; operand[ADDR_W-1:0] is the address, zero-extended if ADDR_W > DATA_W.
//  RESET_PC  0   PC value loaded on reset.
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high
//  mem_req     out  1       memory transaction request
//  mem_we      out  1       1 = write, 0 = read; valid while mem_req
//  mem_addr    out  ADDR_W  transaction address
//  mem_wdata   out  DATA_W  write data
//  mem_rdata   in   DATA_W  read data, sampled when mem_req && mem_ready
//  mem_ready   in   1       transaction completes this cycle when high with mem_req
//  halted      out  1       core is in S_HALT
//  pc_o        out  ADDR_W  current PC (debug)
//  a_o, b_o    out  DATA_W  A and B registers (debug)
//  ccr_o       out  4       {N,Z,V,C}
// BEHAVIOUR
//  Reset: PC=RESET_PC; A,B,IR,MAR,CCR=0; state=S_FETCH. While reset is high, mem_req=mem_we=0,
//   mem_addr=0, mem_wdata=0, halted=0. Reset mid-transaction abandons it; there is no completion.
//  Handshake: mem_addr/mem_we/mem_wdata stay stable while mem_req && !mem_ready. Each completion is
//   exactly one req&&ready cycle; the FSM advances only on completion. mem_req is a function of state.
//  S_FETCH: read at PC. On completion: IR<=rdata, PC<=PC+1 (mod 2^ADDR_W), then S_DECODE.
//  S_DECODE: one cycle, mem_req=0.
//   ALU ops (A<=result, CCR updated) -> S_FETCH.
//   0xFF HLT -> S_HALT.
//   Operand ops -> S_OPER.
//   Undefined opcodes act as NOP -> S_FETCH.
//  S_OPER: read at PC. On completion: PC<=PC+1, then:
//   LDx_IMM: reg<=rdata -> S_FETCH.
//   Direct ops: MAR<=rdata -> S_DATA.
//   Branch: if taken, PC<=rdata instead of PC+1 -> S_FETCH.
//  S_DATA: at MAR. Loads read (reg<=rdata). Stores write (mem_we=1, mem_wdata=A or B). On completion -> S_FETCH.
//  S_HALT: mem_req=0, halted=1. Leaves only on reset.
//  Opcodes:
//   86 LDA_IMM   87 LDA_DIR   88 LDB_IMM   89 LDB_DIR   96 STA_DIR   97 STB_DIR
//   42 ADD A=A+B   43 SUB A=A-B   44 AND   45 OR   46 INCA   47 DECA
//   20 BRA   21 BEQ (Z=1)   22 BCS (C=1)   FF HLT
//  Flags (DATA_W-bit arithmetic, result wraps):
//   N = result MSB. Z = result==0.
//   ADD/INCA: C = carry out; V = signed overflow.
//   SUB/DECA: C = borrow (unsigned minuend < subtrahend); V = signed overflow.
//   AND/OR: V=C=0.
//   Loads, stores and branches leave CCR unchanged.
//  Cycles with mem_ready always high: ALU 2, IMM/branch 3, DIR 4.
// CONFIGURATION
//  CPU_INSTR_CNT_EN defined:
//   Adds output instr_cnt[31:0], cleared by reset.
//   Increments by 1 on the cycle each instruction retires (its final transition into S_FETCH or S_HALT).
//   HLT counts once. Wraps at 2^32.
//  CPU_INSTR_CNT_EN undefined: instr_cnt port and its logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset/fetch: hold reset 2 cycles with mem_ready=1.
//    -> all outputs 0 during reset. First mem_req=1 with addr=RESET_PC (0x00) on the cycle after reset falls.
//  2 Arithmetic, mem_ready=1:
//    program 86 7F 88 01 42 FF -> A=0x80, CCR={N1,Z0,V1,C0}, halted=1, PC=0x06.
//  3 Wait states: ready low for 3 cycles on every request, running test 2.
//    -> addr/we stable while stalled, same final state, total cycles = unstalled + 3 x (requests).
//  4 Store/branch: 86 00 21 06 86 55 96 40 FF.
//    -> BEQ is not taken (CCR Z still 0 after reset) -> write 0x55 to addr 0x40, then halt.
//    Variant: precede with 86 01 88 01 43 so Z=1 -> store is skipped.
//  5 Reset mid-S_DATA while stalled (ready=0).
//    -> mem_req drops during reset, no write occurs, PC=RESET_PC, re-fetch from 0x00.
//  6 CPU_INSTR_CNT_EN with DATA_W=16, ADDR_W=10 running test 2.
//    -> instr_cnt=4; 0x7FFF+0x0001 gives V=1, N=1.

Source files
------------

// File: rtl/cpu_hs_param_if.sv
// Memory handshake bundle between the cpu_hs_param core (master) and memory or an arbiter (slave).
interface cpu_hs_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cpu_hs_param.sv
// Parametrised accumulator CPU (A/B, NZVC) with req/ready memory handshake and HALT state.
// Optional retired-instruction counter output instr_cnt when CPU_INSTR_CNT_EN is defined.
module cpu_hs_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_hs_param_if.master        mem,
    output logic                  halted,
    output logic [ADDR_W-1:0]     pc_o,
    output logic [DATA_W-1:0]     a_o,
    output logic [DATA_W-1:0]     b_o,
    output logic [3:0]            ccr_o
`ifdef CPU_INSTR_CNT_EN
    ,
    output logic [31:0]           instr_cnt
`endif
);

    localparam int                MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD     = 8'h42;
    localparam logic [7:0] OP_SUB     = 8'h43;
    localparam logic [7:0] OP_AND     = 8'h44;
    localparam logic [7:0] OP_OR      = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_DECA    = 8'h47;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BEQ     = 8'h21;
    localparam logic [7:0] OP_BCS     = 8'h22;
    localparam logic [7:0] OP_HLT     = 8'hFF;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPER, S_DATA, S_HALT} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] mar_reg, mar_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [7:0]        ir_reg, ir_next;
    logic [3:0]        ccr_reg, ccr_next;

    logic              req_int, we_int;
    logic [ADDR_W-1:0] addr_int;
    logic [DATA_W-1:0] wdata_int;
    logic [ADDR_W-1:0] operand_addr;
    logic [ADDR_W-1:0] pc_inc;

    logic [DATA_W-1:0] add_rhs, sub_rhs, sub_diff, alu_res;
    logic [DATA_W:0]   add_sum;
    logic              alu_v, alu_c;

    // Operand word -> address: truncate or zero-extend bit by bit.
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_operand_addr
        if (gi < DATA_W) begin : g_bit
            assign operand_addr[gi] = mem.mem_rdata[gi];
        end else begin : g_zero
            assign operand_addr[gi] = 1'b0;
        end
    end

    assign pc_inc = pc_reg + ADDR_W'(1);

    assign add_rhs  = (ir_reg == OP_INCA) ? ONE : b_reg;
    assign sub_rhs  = (ir_reg == OP_DECA) ? ONE : b_reg;
    assign add_sum  = {1'b0, a_reg} + {1'b0, add_rhs};
    assign sub_diff = a_reg - sub_rhs;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (ir_reg)
            OP_ADD, OP_INCA: begin
                alu_res = add_sum[MSB:0];
                alu_c   = add_sum[DATA_W];
                alu_v   = (a_reg[MSB] == add_rhs[MSB]) && (alu_res[MSB] != a_reg[MSB]);
            end
            OP_SUB, OP_DECA: begin
                alu_res = sub_diff;
                alu_c   = (a_reg < sub_rhs);
                alu_v   = (a_reg[MSB] != sub_rhs[MSB]) && (alu_res[MSB] != a_reg[MSB]);
            end
            OP_AND:  alu_res = a_reg & b_reg;
            OP_OR:   alu_res = a_reg | b_reg;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        mar_next   = mar_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        ir_next    = ir_reg;
        ccr_next   = ccr_reg;
        req_int    = 1'b0;
        we_int     = 1'b0;
        addr_int   = '0;
        wdata_int  = '0;
        case (state_reg)
            S_FETCH: begin
                req_int  = 1'b1;
                addr_int = pc_reg;
                if (mem.mem_ready) begin
                    ir_next    = mem.mem_rdata[7:0];
                    pc_next    = pc_inc;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_FETCH;
                case (ir_reg)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INCA, OP_DECA: begin
                        a_next   = alu_res;
                        ccr_next = {alu_res[MSB], (alu_res == '0), alu_v, alu_c};
                    end
                    OP_HLT: state_next = S_HALT;
                    OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR, OP_LDB_DIR,
                    OP_STA_DIR, OP_STB_DIR, OP_BRA, OP_BEQ, OP_BCS:
                        state_next = S_OPER;
                    default: state_next = S_FETCH;
                endcase
            end
            S_OPER: begin
                req_int  = 1'b1;
                addr_int = pc_reg;
                if (mem.mem_ready) begin
                    pc_next    = pc_inc;
                    state_next = S_FETCH;
                    case (ir_reg)
                        OP_LDA_IMM: a_next = mem.mem_rdata;
                        OP_LDB_IMM: b_next = mem.mem_rdata;
                        OP_LDA_DIR, OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: begin
                            mar_next   = operand_addr;
                            state_next = S_DATA;
                        end
                        OP_BRA: pc_next = operand_addr;
                        OP_BEQ: if (ccr_reg[2]) pc_next = operand_addr;
                        OP_BCS: if (ccr_reg[0]) pc_next = operand_addr;
                        default: state_next = S_FETCH;
                    endcase
                end
            end
            S_DATA: begin
                req_int   = 1'b1;
                addr_int  = mar_reg;
                we_int    = (ir_reg == OP_STA_DIR) || (ir_reg == OP_STB_DIR);
                wdata_int = (ir_reg == OP_STB_DIR) ? b_reg : a_reg;
                if (mem.mem_ready) begin
                    if (ir_reg == OP_LDA_DIR) a_next = mem.mem_rdata;
                    if (ir_reg == OP_LDB_DIR) b_next = mem.mem_rdata;
                    state_next = S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
            pc_reg    <= RESET_PC;
            mar_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            ir_reg    <= '0;
            ccr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            mar_reg   <= mar_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            ir_reg    <= ir_next;
            ccr_reg   <= ccr_next;
        end
    end

    // Reset masks the bus combinationally so an in-flight request vanishes immediately.
    assign mem.mem_req   = req_int && !reset;
    assign mem.mem_we    = we_int && !reset;
    assign mem.mem_addr  = reset ? '0 : addr_int;
    assign mem.mem_wdata = reset ? '0 : wdata_int;
    assign halted        = (state_reg == S_HALT) && !reset;
    assign pc_o          = pc_reg;
    assign a_o           = a_reg;
    assign b_o           = b_reg;
    assign ccr_o         = ccr_reg;

`ifdef CPU_INSTR_CNT_EN
    logic        retire;
    logic [31:0] instr_cnt_reg;

    assign retire = (state_reg inside {S_DECODE, S_OPER, S_DATA}) &&
                    (state_next inside {S_FETCH, S_HALT});

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_reg <= '0;
        end else if (retire) begin
            instr_cnt_reg <= instr_cnt_reg + 32'd1;
        end
    end

    assign instr_cnt = instr_cnt_reg;
`else
    // No instruction counter in this build.
`endif

endmodule

// File: tb/tb_cpu_hs_param.sv
// Directed self-checking bench for cpu_hs_param: 8-bit core with wait-state memory model,
// plus a 16-bit data / 10-bit address instance for wide-arithmetic flags.
module tb_cpu_hs_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic reset16 = 1'b1;

    cpu_hs_param_if #(.DATA_W(8),  .ADDR_W(8))  bus8 ();
    cpu_hs_param_if #(.DATA_W(16), .ADDR_W(10)) bus16 ();

    logic        halted8, halted16;
    logic [7:0]  pc8, a8, b8;
    logic [9:0]  pc16;
    logic [15:0] a16, b16;
    logic [3:0]  ccr8, ccr16;
`ifdef CPU_INSTR_CNT_EN
    logic [31:0] cnt8, cnt16;
`endif

    cpu_hs_param #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut8 (
        .clk(clk), .reset(reset), .mem(bus8), .halted(halted8),
        .pc_o(pc8), .a_o(a8), .b_o(b8), .ccr_o(ccr8)
`ifdef CPU_INSTR_CNT_EN
        , .instr_cnt(cnt8)
`endif
    );

    cpu_hs_param #(.DATA_W(16), .ADDR_W(10), .RESET_PC(10'h000)) dut16 (
        .clk(clk), .reset(reset16), .mem(bus16), .halted(halted16),
        .pc_o(pc16), .a_o(a16), .b_o(b16), .ccr_o(ccr16)
`ifdef CPU_INSTR_CNT_EN
        , .instr_cnt(cnt16)
`endif
    );

    // 8-bit memory: ws wait states per request; block_we stalls writes indefinitely.
    logic [7:0]  mem8 [256];
    logic [15:0] mem16 [1024];
    int          ws = 0;
    bit          block_we = 1'b0;
    int          stall_cnt = 0;
    int          wr_count = 0;

    always_comb begin
        bus8.mem_rdata = mem8[bus8.mem_addr];
        bus8.mem_ready = (stall_cnt >= ws) && !(block_we && bus8.mem_we);
        bus16.mem_rdata = mem16[bus16.mem_addr];
        bus16.mem_ready = 1'b1;
    end

    always @(posedge clk) begin
        if (bus8.mem_req && bus8.mem_ready) begin
            stall_cnt <= 0;
            if (bus8.mem_we) begin
                mem8[bus8.mem_addr] = bus8.mem_wdata;
                wr_count = wr_count + 1;
            end
        end else if (bus8.mem_req) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt <= 0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int unstable = 0;
    int cycles;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First program byte sits in the most significant occupied byte of img.
    task automatic load8(input logic [127:0] img, input int n);
        for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
        for (int i = 0; i < n; i++) mem8[i] = img[8*(n-1-i) +: 8];
    endtask

    task automatic pulse_reset8;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic run8(input int bound, output int cyc);
        logic       p_req, p_ready, p_we;
        logic [7:0] p_addr;
        cyc = 0;
        while (!halted8 && cyc < bound) begin
            p_req   = bus8.mem_req;
            p_ready = bus8.mem_ready;
            p_we    = bus8.mem_we;
            p_addr  = bus8.mem_addr;
            tick;
            cyc++;
            if (p_req && !p_ready &&
                !(bus8.mem_req && bus8.mem_we == p_we && bus8.mem_addr == p_addr))
                unstable++;
        end
    endtask

    initial begin
        // Reset and arithmetic: 86 7F 88 01 42 FF
        load8(128'({8'h86, 8'h7F, 8'h88, 8'h01, 8'h42, 8'hFF}), 6);
        ws = 0;
        reset = 1'b1;
        tick;
        tick;
        chk("rst_req",   32'(bus8.mem_req),   32'h0);
        chk("rst_we",    32'(bus8.mem_we),    32'h0);
        chk("rst_addr",  32'(bus8.mem_addr),  32'h0);
        chk("rst_wdata", 32'(bus8.mem_wdata), 32'h0);
        chk("rst_halt",  32'(halted8),        32'h0);
        chk("rst_pc",    32'(pc8),            32'h0);
        chk("rst_a",     32'(a8),             32'h0);
        chk("rst_b",     32'(b8),             32'h0);
        chk("rst_ccr",   32'(ccr8),           32'h0);
        reset = 1'b0;
        #1;
        chk("first_req",  32'(bus8.mem_req),  32'h1);
        chk("first_addr", 32'(bus8.mem_addr), 32'h0);
        chk("first_we",   32'(bus8.mem_we),   32'h0);
        run8(100, cycles);
        chk("add_cycles", 32'(cycles),  32'd10);
        chk("add_halt",   32'(halted8), 32'h1);
        chk("add_a",      32'(a8),      32'h80);
        chk("add_b",      32'(b8),      32'h01);
        chk("add_ccr",    32'(ccr8),    32'hA);
        chk("add_pc",     32'(pc8),     32'h06);
`ifdef CPU_INSTR_CNT_EN
        chk("add_icnt",   cnt8,         32'd4);
`endif
        $display("[TB] add program: cycles=%0d A=%0h CCR=%0h", cycles, a8, ccr8);

        // Same program with 3 wait states per request (6 requests)
        ws = 3;
        unstable = 0;
        pulse_reset8;
        run8(200, cycles);
        chk("ws_cycles",   32'(cycles),   32'd28);
        chk("ws_unstable", 32'(unstable), 32'd0);
        chk("ws_halt",     32'(halted8),  32'h1);
        chk("ws_a",        32'(a8),       32'h80);
        chk("ws_ccr",      32'(ccr8),     32'hA);
        chk("ws_pc",       32'(pc8),      32'h06);
        $display("[TB] wait-state program: cycles=%0d", cycles);

        // BEQ not taken, store 0x55 to 0x40
        ws = 0;
        load8(128'({8'h86, 8'h00, 8'h21, 8'h06, 8'h86, 8'h55, 8'h96, 8'h40, 8'hFF}), 9);
        mem8[8'h40] = 8'hEE;
        wr_count = 0;
        pulse_reset8;
        run8(100, cycles);
        chk("st_cycles", 32'(cycles),      32'd15);
        chk("st_wrcnt",  32'(wr_count),    32'd1);
        chk("st_mem40",  32'(mem8[8'h40]), 32'h55);
        chk("st_a",      32'(a8),          32'h55);
        chk("st_ccr",    32'(ccr8),        32'h0);
        chk("st_pc",     32'(pc8),         32'h09);
        $display("[TB] store program: writes=%0d mem[40]=%0h", wr_count, mem8[8'h40]);

        // SUB sets Z, BEQ taken over the store to HLT at 0x0D
        load8(128'({8'h86, 8'h01, 8'h88, 8'h01, 8'h43, 8'h86, 8'h00, 8'h21, 8'h0D,
                    8'h86, 8'h55, 8'h96, 8'h40, 8'hFF}), 14);
        mem8[8'h40] = 8'hEE;
        wr_count = 0;
        pulse_reset8;
        run8(100, cycles);
        chk("bq_cycles", 32'(cycles),      32'd16);
        chk("bq_wrcnt",  32'(wr_count),    32'd0);
        chk("bq_mem40",  32'(mem8[8'h40]), 32'hEE);
        chk("bq_a",      32'(a8),          32'h00);
        chk("bq_ccr",    32'(ccr8),        32'h4);
        chk("bq_pc",     32'(pc8),         32'h0E);
        $display("[TB] branch-taken program: writes=%0d PC=%0h", wr_count, pc8);

        // INCA wrap sets C, BCS taken, DECA, AND clears C, OR
        load8(128'({8'h86, 8'hFF, 8'h46, 8'h22, 8'h07, 8'hFF, 8'hFF, 8'h47,
                    8'h88, 8'hF0, 8'h44, 8'h88, 8'h00, 8'h45, 8'hFF}), 15);
        pulse_reset8;
        run8(100, cycles);
        chk("lg_cycles", 32'(cycles), 32'd22);
        chk("lg_a",      32'(a8),     32'hF0);
        chk("lg_b",      32'(b8),     32'h00);
        chk("lg_ccr",    32'(ccr8),   32'h8);
        chk("lg_pc",     32'(pc8),    32'h0F);
        $display("[TB] logic program: A=%0h CCR=%0h PC=%0h", a8, ccr8, pc8);

        // Reset during a stalled store
        load8(128'({8'h86, 8'h55, 8'h96, 8'h40, 8'hFF}), 5);
        block_we = 1'b1;
        wr_count = 0;
        pulse_reset8;
        for (int k = 0; k < 50 && !bus8.mem_we; k++) tick;
        chk("stl_we",    32'(bus8.mem_we),    32'h1);
        chk("stl_addr",  32'(bus8.mem_addr),  32'h40);
        chk("stl_wdata", 32'(bus8.mem_wdata), 32'h55);
        tick;
        tick;
        chk("stl_hold_req",  32'(bus8.mem_req),  32'h1);
        chk("stl_hold_addr", 32'(bus8.mem_addr), 32'h40);
        reset = 1'b1;
        #1;
        chk("mr_req",  32'(bus8.mem_req),  32'h0);
        chk("mr_we",   32'(bus8.mem_we),   32'h0);
        chk("mr_addr", 32'(bus8.mem_addr), 32'h0);
        tick;
        chk("mr_pc",    32'(pc8),      32'h0);
        chk("mr_a",     32'(a8),       32'h0);
        chk("mr_wrcnt", 32'(wr_count), 32'd0);
        block_we = 1'b0;
        reset = 1'b0;
        #1;
        chk("mr_refetch_req",  32'(bus8.mem_req),  32'h1);
        chk("mr_refetch_addr", 32'(bus8.mem_addr), 32'h0);
        $display("[TB] mid-store reset: writes=%0d PC=%0h", wr_count, pc8);

        // 16-bit data, 10-bit address; HLT word carries junk in upper IR bits
        for (int i = 0; i < 1024; i++) mem16[i] = 16'h0000;
        mem16[0] = 16'h0086;
        mem16[1] = 16'h7FFF;
        mem16[2] = 16'h0088;
        mem16[3] = 16'h0001;
        mem16[4] = 16'h0042;
        mem16[5] = 16'h12FF;
        reset16 = 1'b1;
        tick;
        reset16 = 1'b0;
        cycles = 0;
        while (!halted16 && cycles < 100) begin
            tick;
            cycles++;
        end
        chk("w16_cycles", 32'(cycles),   32'd10);
        chk("w16_halt",   32'(halted16), 32'h1);
        chk("w16_a",      32'(a16),      32'h8000);
        chk("w16_ccr",    32'(ccr16),    32'hA);
        chk("w16_pc",     32'(pc16),     32'h006);
`ifdef CPU_INSTR_CNT_EN
        chk("w16_icnt",   cnt16,         32'd4);
`endif
        $display("[TB] 16-bit program: A=%0h CCR=%0h PC=%0h", a16, ccr16, pc16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
